debounce_edge_detect: RTL and testbench
=======================================

Name: debounce_edge_detect

Overview:
- Per-channel glitch filter and edge detector. Sits directly downstream of the synchronization chain and consumes its already-synchronized data output.
- Each channel publishes a debounced level once the input has held a new value for DEBOUNCE_CYCLES consecutive enabled cycles.
- Each debounced transition produces a single-cycle rise or fall pulse.
- Feeds control logic that needs clean level and edge events from external or cross-domain signals.

Parameters:
- CHANNEL_COUNT, 4: number of independent channels (width of data_i and all outputs); must be >= 1.
- DEBOUNCE_CYCLES, 16: consecutive enabled cycles of a differing input required to accept a new level; must be >= 1.
- RESET_LEVEL, {CHANNEL_COUNT{1'b0}}: per-channel debounced level loaded on reset.

Ports:
- clk_dom_i  input  sys_structs::clk_dom_sain  clock-domain bundle:
  - clk_dom_i.clk: the single clock.
  - clk_dom_i.sync_rst: reset. One clock; reset is synchronous and active-high.
  - clk_dom_i.clk_en: cycle enable.
- data_i  input  CHANNEL_COUNT  synchronized raw inputs from the synchronization chain.
- level_o  output  CHANNEL_COUNT  debounced level (registered).
- rise_o  output  CHANNEL_COUNT  one-cycle pulse; debounced level went 0->1.
- fall_o  output  CHANNEL_COUNT  one-cycle pulse; debounced level went 1->0.
- stable_o  output  CHANNEL_COUNT  high when the channel counter is 0, i.e. data_i matched level_o at the last enabled sample.

Behaviour:
- Per channel n, state is level[n] plus counter cnt[n] of width $clog2(DEBOUNCE_CYCLES+1), saturating at DEBOUNCE_CYCLES-1. Channels are fully independent.
- Reset (sync_rst high at a posedge; overrides clk_en):
  - level_o = RESET_LEVEL; all cnt = 0.
  - rise_o = fall_o = 0; stable_o = all 1.
- Enabled cycle (clk_en=1, no reset):
  - data_i[n] == level[n]: cnt[n] <= 0. Any partial count is discarded (glitch rejection).
  - data_i[n] != level[n] and cnt[n] < DEBOUNCE_CYCLES-1: cnt[n] <= cnt[n]+1.
  - data_i[n] != level[n] and cnt[n] == DEBOUNCE_CYCLES-1: level[n] <= data_i[n]; cnt[n] <= 0; rise_o[n] <= data_i[n]; fall_o[n] <= ~data_i[n].
  - In every other enabled case, rise_o[n] and fall_o[n] <= 0.
- Latency: if data_i differs from level_o at enabled sample edges k .. k+DEBOUNCE_CYCLES-1, level_o and the matching pulse update at edge k+DEBOUNCE_CYCLES-1.
  - DEBOUNCE_CYCLES=1 degenerates to a registered follower with edge pulses.
- Disabled cycle (clk_en=0, no reset):
  - level and cnt hold.
  - rise_o and fall_o are forced to 0 at the next edge, so every pulse is exactly one clk cycle wide.
- rise_o[n] and fall_o[n] are never high simultaneously. A channel cannot pulse on two consecutive cycles unless DEBOUNCE_CYCLES=1.
- Reset mid-count: the count is lost and level returns to RESET_LEVEL with no pulse, even if that changes level_o.
- After reset, an input held opposite to RESET_LEVEL is accepted after DEBOUNCE_CYCLES enabled cycles, with a normal pulse.
- stable_o[n] = (cnt[n] == 0), decoded from registered state.
- No combinational path from data_i to any output.

Test Plan:
- Reset, then data_i=4'b0001 held with clk_en=1, DEBOUNCE_CYCLES=16 -> level_o[0] rises at the 16th enabled edge; rise_o=4'b0001 for exactly 1 cycle; stable_o[0] low for cycles 1-15, then high.
- Glitch: data_i[1]=1 for 15 cycles, 0 for 1 cycle, then 1 again -> no change at cycle 16; level_o[1]=1 and rise_o[1] pulse only after 16 further consecutive cycles.
- clk_en toggling 1/0 every cycle with data_i[2]=1 -> counter advances only on enabled edges; level_o[2] rises after 16 enabled edges (31 clk edges from first sample); rise_o[2] still 1 cycle wide.
- Falling edge: with level_o=4'b1111, drive data_i=4'b0101 for 16 cycles -> level_o=4'b0101; fall_o=4'b1010 for 1 cycle; rise_o stays 0.
- Reset mid-operation: RESET_LEVEL=4'b0000; accept level_o[3]=1 (data_i[3]=1 for 16 cycles); release data_i[3]=0, assert sync_rst at count 10 -> level_o=4'b0000, rise_o=fall_o=0, stable_o=4'b1111; a following 16-cycle high input produces a normal rise.
- DEBOUNCE_CYCLES=1 variant: data_i pattern 0,1,1,0 -> level_o follows one cycle later; rise_o pulses once, then fall_o pulses once.

Source files
------------

// File: rtl/sys_structs.sv
// Shared clock-domain bundle type used by blocks that take clock, reset and enable as one port.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package sys_structs;

    // One clock, its synchronous active-high reset and a per-cycle enable.
    typedef struct packed {
        logic clk;
        logic sync_rst;
        logic clk_en;
    } clk_dom_sain;

endpackage

// File: rtl/debounce_edge_detect.sv
// Per-channel glitch filter: publishes a new level after DEBOUNCE_CYCLES consecutive
// enabled samples that differ from it, and emits a one-cycle rise/fall pulse on each change.
// Latency: level/pulse update on the DEBOUNCE_CYCLES-th differing enabled edge; no backpressure.
//
// Ports:
//   clk_dom_i : clock, synchronous active-high reset, cycle enable
//   data_i    : already-synchronized raw inputs, one bit per channel
//   level_o   : debounced level (registered)
//   rise_o    : one-cycle pulse when the debounced level goes 0->1
//   fall_o    : one-cycle pulse when the debounced level goes 1->0
//   stable_o  : channel counter is zero (input matched level at the last enabled sample)
module debounce_edge_detect #(
    parameter int                       CHANNEL_COUNT   = 4,
    parameter int                       DEBOUNCE_CYCLES = 16,
    parameter logic [CHANNEL_COUNT-1:0] RESET_LEVEL     = {CHANNEL_COUNT{1'b0}}
) (
    input  sys_structs::clk_dom_sain   clk_dom_i,
    input  logic [CHANNEL_COUNT-1:0]   data_i,
    output logic [CHANNEL_COUNT-1:0]   level_o,
    output logic [CHANNEL_COUNT-1:0]   rise_o,
    output logic [CHANNEL_COUNT-1:0]   fall_o,
    output logic [CHANNEL_COUNT-1:0]   stable_o
);

    localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
    // The counter never needs to reach DEBOUNCE_CYCLES: the accepting sample is the
    // one that finds it already at DEBOUNCE_CYCLES-1.
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [CHANNEL_COUNT-1:0] level_q;
    logic [CHANNEL_COUNT-1:0] rise_q;
    logic [CHANNEL_COUNT-1:0] fall_q;
    logic [CW-1:0]            cnt_q [CHANNEL_COUNT];

    always_ff @(posedge clk_dom_i.clk) begin
        if (clk_dom_i.sync_rst) begin
            level_q <= RESET_LEVEL;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int n = 0; n < CHANNEL_COUNT; n++) begin
                cnt_q[n] <= '0;
            end
        end else if (clk_dom_i.clk_en) begin
            for (int n = 0; n < CHANNEL_COUNT; n++) begin
                rise_q[n] <= 1'b0;
                fall_q[n] <= 1'b0;
                if (data_i[n] == level_q[n]) begin
                    // Any partial count is a glitch; throw it away.
                    cnt_q[n] <= '0;
                end else if (cnt_q[n] == CNT_MAX) begin
                    level_q[n] <= data_i[n];
                    cnt_q[n]   <= '0;
                    rise_q[n]  <= data_i[n];
                    fall_q[n]  <= ~data_i[n];
                end else begin
                    cnt_q[n] <= cnt_q[n] + CW'(1);
                end
            end
        end else begin
            // Level and counters hold; pulses still drop so each is one clk wide.
            rise_q <= '0;
            fall_q <= '0;
        end
    end

    always_comb begin
        stable_o = '0;
        for (int n = 0; n < CHANNEL_COUNT; n++) begin
            stable_o[n] = (cnt_q[n] == '0);
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Bench for debounce_edge_detect: a DEBOUNCE_CYCLES=16 instance driven by hand-written
// sequences and a DEBOUNCE_CYCLES=1 instance driven from a vector table; expected outputs
// are queued when inputs are driven and popped/compared one clock later.
module tb_debounce_edge_detect;

    typedef struct {
        int         sel;
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] stb;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] d;
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] stb;
    } vec_t;

    logic clk;
    logic rst16, en16, rst1, en1;
    logic [3:0] d16, d1;
    logic [3:0] lvl16, rise16, fall16, stb16;
    logic [3:0] lvl1, rise1, fall1, stb1;
    sys_structs::clk_dom_sain cd16, cd1;

    assign cd16 = '{clk: clk, sync_rst: rst16, clk_en: en16};
    assign cd1  = '{clk: clk, sync_rst: rst1,  clk_en: en1};

    debounce_edge_detect #(
        .CHANNEL_COUNT(4), .DEBOUNCE_CYCLES(16), .RESET_LEVEL(4'b0000)
    ) dut (
        .clk_dom_i(cd16), .data_i(d16), .level_o(lvl16),
        .rise_o(rise16), .fall_o(fall16), .stable_o(stb16)
    );

    debounce_edge_detect #(
        .CHANNEL_COUNT(4), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(4'b0000)
    ) dut1 (
        .clk_dom_i(cd1), .data_i(d1), .level_o(lvl1),
        .rise_o(rise1), .fall_o(fall1), .stable_o(stb1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t  expq[$];
    int    total = 0;
    int    bad   = 0;
    string tag   = "init";

    task automatic check_one();
        exp_t e;
        logic [3:0] al, ar, af, as;
        total++;
        if (expq.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty when output expected", tag);
            return;
        end
        e = expq.pop_front();
        if (e.sel == 0) begin
            al = lvl16; ar = rise16; af = fall16; as = stb16;
        end else begin
            al = lvl1;  ar = rise1;  af = fall1;  as = stb1;
        end
        if (al !== e.lvl || ar !== e.rise || af !== e.fall || as !== e.stb) begin
            bad++;
            $display("FAIL %s: dut%0d got lvl=%b rise=%b fall=%b stb=%b want lvl=%b rise=%b fall=%b stb=%b",
                     tag, e.sel, al, ar, af, as, e.lvl, e.rise, e.fall, e.stb);
        end
    endtask

    // Drive one cycle of inputs to the selected instance, queue what it must show after
    // the coming edge, then sample #1 after that edge.
    task automatic step(input int sel, input logic rst, input logic en, input logic [3:0] d,
                        input logic [3:0] el, input logic [3:0] er,
                        input logic [3:0] ef, input logic [3:0] es);
        exp_t e;
        e.sel = sel; e.lvl = el; e.rise = er; e.fall = ef; e.stb = es;
        if (sel == 0) begin
            rst16 = rst; en16 = en; d16 = d;
        end else begin
            rst1 = rst; en1 = en; d1 = d;
        end
        expq.push_back(e);
        @(posedge clk);
        #1;
        check_one();
    endtask

    // Hold d for n enabled cycles on the 16-cycle instance, starting from level lv with
    // all counters at zero; the last cycle accepts the change to nl.
    task automatic accept16(input logic [3:0] d, input logic [3:0] lv, input logic [3:0] nl);
        logic [3:0] diff;
        diff = d ^ lv;
        for (int i = 1; i <= 16; i++) begin
            if (i < 16) step(0, 1'b0, 1'b1, d, lv, 4'b0000, 4'b0000, ~diff);
            else        step(0, 1'b0, 1'b1, d, nl, nl & ~lv, lv & ~nl, 4'b1111);
        end
    endtask

    vec_t tbl [12];

    function automatic vec_t mk(input logic rst, input logic en, input logic [3:0] d,
                                input logic [3:0] l, input logic [3:0] r,
                                input logic [3:0] f, input logic [3:0] s);
        vec_t v;
        v.rst = rst; v.en = en; v.d = d; v.lvl = l; v.rise = r; v.fall = f; v.stb = s;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
        $fatal(1, "timeout");
    end

    initial begin
        // DEBOUNCE_CYCLES=1: level follows the input one edge later, with pulses.
        tbl[0]  = mk(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF);
        tbl[1]  = mk(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF);
        tbl[2]  = mk(0, 1, 4'h1, 4'h1, 4'h1, 4'h0, 4'hF);
        tbl[3]  = mk(0, 1, 4'h1, 4'h1, 4'h0, 4'h0, 4'hF);
        tbl[4]  = mk(0, 1, 4'h0, 4'h0, 4'h0, 4'h1, 4'hF);
        tbl[5]  = mk(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF);
        tbl[6]  = mk(0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF);
        tbl[7]  = mk(0, 1, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF);
        tbl[8]  = mk(0, 0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF);
        tbl[9]  = mk(0, 1, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF);
        tbl[10] = mk(0, 1, 4'h5, 4'h5, 4'h5, 4'h0, 4'hF);
        tbl[11] = mk(1, 0, 4'hA, 4'h0, 4'h0, 4'h0, 4'hF);

        rst16 = 1'b1; en16 = 1'b0; d16 = 4'h0;
        rst1  = 1'b1; en1  = 1'b0; d1  = 4'h0;

        tag = "dc1_table";
        for (int i = 0; i < 12; i++) begin
            step(1, tbl[i].rst, tbl[i].en, tbl[i].d,
                 tbl[i].lvl, tbl[i].rise, tbl[i].fall, tbl[i].stb);
        end
        rst1 = 1'b0; en1 = 1'b0;

        // Reset state of the 16-cycle instance.
        tag = "reset";
        step(0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF);

        // Channel 0 rises on the 16th enabled edge.
        tag = "rise_ch0";
        accept16(4'b0001, 4'b0000, 4'b0001);
        step(0, 1'b0, 1'b1, 4'b0001, 4'b0001, 4'h0, 4'h0, 4'hF);

        // Glitch on channel 1: 15 highs, one low, then a full 16 highs.
        tag = "glitch_ch1";
        for (int i = 1; i <= 15; i++)
            step(0, 1'b0, 1'b1, 4'b0011, 4'b0001, 4'h0, 4'h0, 4'b1101);
        step(0, 1'b0, 1'b1, 4'b0001, 4'b0001, 4'h0, 4'h0, 4'hF);
        accept16(4'b0011, 4'b0001, 4'b0011);
        step(0, 1'b0, 1'b1, 4'b0011, 4'b0011, 4'h0, 4'h0, 4'hF);

        // Channel 2 with the enable toggling every cycle: 31 edges to accept.
        tag = "clken_ch2";
        for (int e = 1; e <= 16; e++) begin
            if (e < 16) begin
                step(0, 1'b0, 1'b1, 4'b0111, 4'b0011, 4'h0, 4'h0, 4'b1011);
                step(0, 1'b0, 1'b0, 4'b0111, 4'b0011, 4'h0, 4'h0, 4'b1011);
            end else begin
                step(0, 1'b0, 1'b1, 4'b0111, 4'b0111, 4'b0100, 4'h0, 4'hF);
                step(0, 1'b0, 1'b0, 4'b0111, 4'b0111, 4'h0, 4'h0, 4'hF);
            end
        end

        // Bring everything to 1111, then fall channels 1 and 3.
        tag = "fall_1010";
        accept16(4'b1111, 4'b0111, 4'b1111);
        accept16(4'b0101, 4'b1111, 4'b0101);
        step(0, 1'b0, 1'b1, 4'b0101, 4'b0101, 4'h0, 4'h0, 4'hF);

        // Accept channel 3 high, release it, reset at count 10 (enable low: reset wins).
        tag = "reset_mid";
        accept16(4'b1101, 4'b0101, 4'b1101);
        for (int i = 1; i <= 10; i++)
            step(0, 1'b0, 1'b1, 4'b0101, 4'b1101, 4'h0, 4'h0, 4'b0111);
        step(0, 1'b1, 1'b0, 4'b0101, 4'b0000, 4'h0, 4'h0, 4'hF);
        tag = "post_reset_rise";
        accept16(4'b1000, 4'b0000, 4'b1000);
        step(0, 1'b0, 1'b1, 4'b1000, 4'b1000, 4'h0, 4'h0, 4'hF);

        if (expq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", expq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
